// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared definitions for the fetch-stage PC redirect logic.
//   pc_state_e        : fetch FSM states (BOOT, RUN, REDIR)
//   INSTR_BYTES       : size of one instruction in bytes (PC step)
//   DEFAULT_RESET_PC  : default fetch address loaded at reset
//   align_target()    : forces a branch target onto a word boundary
package riscv_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2
  } pc_state_e;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Branch targets with nonzero low bits are truncated to the word they fall in.
  function automatic logic [31:0] align_target(input logic [31:0] target);
    return {target[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that stops at its all-ones value instead of wrapping.
// Ports:
//   clk   : clock, counts on rising edge
//   rst_n : asynchronous active-low reset, clears the count
//   en    : count enable, one increment per enabled edge
//   count : current count value
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Hold at all-ones once reached so the count never rolls back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl
// Fetch-stage program counter with branch redirect and pipeline flush control.
// Ports:
//   i_clk, i_rst_n     : clock and asynchronous active-low reset
//   i_stall            : hazard unit request to hold the PC (honoured only in RUN)
//   i_PCSrc            : branch taken from the MEM-stage branch unit
//   i_branch_target    : branch target address from EX/MEM
//   o_pc, o_pc_plus4   : current fetch address and its sequential successor
//   o_fetch_valid      : instruction memory data for o_pc is usable
//   o_flush_*          : flush requests for IF/ID, ID/EX and EX/MEM
//   o_misaligned       : one-cycle pulse after accepting a non word-aligned target
//   o_taken_cnt        : saturating count of taken redirects
module pc_redirect_ctrl
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_PCSrc,
  input  logic [31:0] i_branch_target,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic        o_fetch_valid,
  output logic        o_flush_IFID,
  output logic        o_flush_IDEX,
  output logic        o_flush_EXMEM,
  output logic        o_misaligned,
  output logic [31:0] o_taken_cnt
);

  localparam logic [31:0] PC_STEP = 32'(INSTR_BYTES);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        misaligned_q;

  // State, PC and misaligned pulse registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      misaligned_q <= i_PCSrc && (i_branch_target[1:0] != 2'b00);
    end
  end

  // Next-state and next-PC. BOOT and REDIR never advance the PC, so the first
  // RUN cycle after either one fetches the address already held. A taken
  // branch overrides everything, including stall.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      BOOT:  state_d = RUN;
      RUN:   if (!i_stall) pc_d = pc_q + PC_STEP;
      REDIR: state_d = RUN;
      default: begin
        state_d = BOOT;
        pc_d    = RESET_PC;
      end
    endcase
    if (i_PCSrc) begin
      state_d = REDIR;
      pc_d    = align_target(i_branch_target);
    end
  end

  // Flushes are gated by reset so a stray branch signal during reset is inert.
  // IF/ID is flushed again in REDIR because the word fetched during the
  // redirect cycle came from the old path.
  always_comb begin
    o_flush_IFID  = i_rst_n && (i_PCSrc || (state_q == REDIR));
    o_flush_IDEX  = i_rst_n && i_PCSrc;
    o_flush_EXMEM = i_rst_n && i_PCSrc;
  end

  assign o_pc          = pc_q;
  assign o_pc_plus4    = pc_q + PC_STEP;
  assign o_fetch_valid = (state_q == RUN);
  assign o_misaligned  = misaligned_q;

  sat_counter #(
    .WIDTH(32)
  ) u_taken_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .en    (i_PCSrc),
    .count (o_taken_cnt)
  );

endmodule
